// File: rtl/memx_ctrl_pkg.sv
// Shared types and constants for the memristor write-verify controller.
// Amplitudes are DAC codes; conductance codes grow with cell conductance.
package memx_ctrl_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DAC_W      = 6;
  localparam int unsigned TOL_W      = 4;
  localparam int unsigned PCNT_W     = 6;
  localparam int unsigned TMR_W      = 8;

  localparam logic [DAC_W-1:0] V_READ  = DAC_W'(4);
  localparam logic [DAC_W-1:0] V_START = DAC_W'(24);
  localparam logic [DAC_W-1:0] V_STEP  = DAC_W'(2);
  localparam logic [DAC_W-1:0] V_MAX   = DAC_W'(63);

  localparam int unsigned PULSE_CYC  = 16;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned ADC_TMO    = 255;
  localparam int unsigned MAX_PULSES = 32;

  localparam logic POL_SET = 1'b1;
  localparam logic POL_RST = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETTLE,
    S_RD_CONV,
    S_COMPARE,
    S_PULSE,
    S_GAP,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_FAIL  = 2'd1,
    ST_TMO   = 2'd2,
    ST_ABORT = 2'd3
  } status_e;

  typedef struct packed {
    status_e             status;
    logic [DATA_W-1:0]   code;
    logic [PCNT_W-1:0]   pulses;
  } rsp_t;

  typedef struct packed {
    logic              en;
    logic              pol;
    logic [DAC_W-1:0]  code;
  } drv_t;

  // Next ISPP amplitude, saturating at V_MAX instead of wrapping.
  function automatic logic [DAC_W-1:0] amp_step(input logic [DAC_W-1:0] amp);
    logic [DAC_W:0] sum;
    sum = {1'b0, amp} + (DAC_W+1)'(V_STEP);
    if (sum > {1'b0, V_MAX}) begin
      amp_step = V_MAX;
    end else begin
      amp_step = sum[DAC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/memx_cycle_timer.sv
// Loadable down-counter: a load of N makes done_c high in the Nth cycle after the load.
// done_next_c flags that done_c will be high in the following cycle.
module memx_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c,
  output logic         done_next_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c      = (cnt_q == W'(1));
  assign done_next_c = (cnt_d == W'(1));

endmodule

// File: rtl/memx_write_verify_ctrl.sv
// Write-verify sequencer for one memristor cell: read, compare, ISPP pulse, repeat.
// All outputs are registered from the next-state values, so they follow the state with no extra lag.
module memx_write_verify_ctrl
  import memx_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_target,
  input  logic [TOL_W-1:0]  req_tol,
  input  logic              abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_code,
  output logic [PCNT_W-1:0] rsp_pulses,
  output logic              drv_en,
  output logic              drv_pol,
  output logic [DAC_W-1:0]  drv_code,
  output logic              adc_start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   target_q, target_d;
  logic [TOL_W-1:0]    tol_q, tol_d;
  logic [DATA_W-1:0]   meas_q, meas_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [DAC_W-1:0]    amp_q, amp_d;
  logic                last_pol_q, last_pol_d;
  logic                pol_q, pol_d;
  status_e             status_q, status_d;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  rsp_t                rsp_q, rsp_d;
  drv_t                drv_q, drv_d;
  logic                adc_start_q, adc_start_d;

  logic                tmr_load_c;
  logic [TMR_W-1:0]    tmr_val_c;
  logic                tmr_done_c;
  logic                tmr_done_next_c;

  logic signed [DATA_W:0] diff_c;
  logic [DATA_W:0]        abs_diff_c;
  logic                   in_tol_c;
  logic                   need_set_c;
  logic                   active_c;

  memx_cycle_timer #(.W(TMR_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (tmr_load_c),
    .load_val    (tmr_val_c),
    .done_c      (tmr_done_c),
    .done_next_c (tmr_done_next_c)
  );

  // Signed error of the latest measurement against the target.
  assign diff_c     = $signed({1'b0, meas_q}) - $signed({1'b0, target_q});
  assign abs_diff_c = diff_c[DATA_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
  assign in_tol_c   = (abs_diff_c <= (DATA_W+1)'(tol_q));
  assign need_set_c = diff_c[DATA_W];
  assign active_c   = (state_q != S_IDLE) && (state_q != S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the datapath registers that move with each transition.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    tol_d      = tol_q;
    meas_d     = meas_q;
    pcnt_d     = pcnt_q;
    amp_d      = amp_q;
    last_pol_d = last_pol_q;
    pol_d      = pol_q;
    status_d   = status_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    if (active_c && abort) begin
      state_d  = S_RESP;
      status_d = ST_ABORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            target_d   = req_target;
            tol_d      = req_tol;
            meas_d     = '0;
            pcnt_d     = '0;
            amp_d      = V_START;
            state_d    = S_RD_SETTLE;
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(SETTLE_CYC);
          end
        end
        S_RD_SETTLE: begin
          if (tmr_done_c) begin
            state_d    = S_RD_CONV;
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(ADC_TMO);
          end
        end
        S_RD_CONV: begin
          // A result on the expiry cycle still counts.
          if (adc_valid) begin
            meas_d  = adc_data;
            state_d = S_COMPARE;
          end else if (tmr_done_c) begin
            status_d = ST_TMO;
            state_d  = S_RESP;
          end
        end
        S_COMPARE: begin
          if (in_tol_c) begin
            status_d = ST_OK;
            state_d  = S_RESP;
          end else if (pcnt_q == PCNT_W'(MAX_PULSES)) begin
            status_d = ST_FAIL;
            state_d  = S_RESP;
          end else begin
            pol_d = need_set_c ? POL_SET : POL_RST;
            if (need_set_c != last_pol_q) begin
              amp_d = V_START;
            end else if (pcnt_q != '0) begin
              amp_d = amp_step(amp_q);
            end
            last_pol_d = need_set_c;
            pcnt_d     = pcnt_q + PCNT_W'(1);
            state_d    = S_PULSE;
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(PULSE_CYC);
          end
        end
        S_PULSE: begin
          if (tmr_done_c) begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          state_d    = S_RD_SETTLE;
          tmr_load_c = 1'b1;
          tmr_val_c  = TMR_W'(SETTLE_CYC);
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output values for the cycle after this edge; polarity holds while the driver is off.
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_d       = '0;
    drv_d       = '{en: 1'b0, pol: drv_q.pol, code: '0};
    adc_start_d = 1'b0;

    case (state_d)
      S_IDLE: begin
        req_ready_d = 1'b1;
      end
      S_RD_SETTLE: begin
        drv_d       = '{en: 1'b1, pol: POL_SET, code: V_READ};
        adc_start_d = tmr_done_next_c;
      end
      S_RD_CONV: begin
        drv_d = '{en: 1'b1, pol: POL_SET, code: V_READ};
      end
      S_PULSE: begin
        drv_d = '{en: 1'b1, pol: pol_d, code: amp_d};
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_d       = '{status: status_d, code: meas_d, pulses: pcnt_d};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      tol_q       <= '0;
      meas_q      <= '0;
      pcnt_q      <= '0;
      amp_q       <= V_START;
      last_pol_q  <= POL_SET;
      pol_q       <= POL_SET;
      status_q    <= ST_OK;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      drv_q       <= '0;
      adc_start_q <= 1'b0;
    end else begin
      target_q    <= target_d;
      tol_q       <= tol_d;
      meas_q      <= meas_d;
      pcnt_q      <= pcnt_d;
      amp_q       <= amp_d;
      last_pol_q  <= last_pol_d;
      pol_q       <= pol_d;
      status_q    <= status_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      drv_q       <= drv_d;
      adc_start_q <= adc_start_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_q.status;
  assign rsp_code   = rsp_q.code;
  assign rsp_pulses = rsp_q.pulses;
  assign drv_en     = drv_q.en;
  assign drv_pol    = drv_q.pol;
  assign drv_code   = drv_q.code;
  assign adc_start  = adc_start_q;

endmodule

// File: tb/tb_memx_write_verify_ctrl.sv
// Bench for memx_write_verify_ctrl: behavioural memristor cell + ADC, with a
// request-level reference model predicting pulse train and response.
module tb_memx_write_verify_ctrl;
  import memx_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, abort, rsp_valid, rsp_ready;
  logic              drv_en, drv_pol, adc_start, adc_valid;
  logic [DATA_W-1:0] req_target, rsp_code, adc_data;
  logic [TOL_W-1:0]  req_tol;
  logic [1:0]        rsp_status;
  logic [PCNT_W-1:0] rsp_pulses;
  logic [DAC_W-1:0]  drv_code;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // Cell and ADC environment state
  int g, set_gain, rst_gain;
  int adc_mode;        // 0 random latency, 1 never answers, 2 fixed latency
  int adc_fixed_lat;
  int lat_cnt;
  bit pending;
  int unsigned start_cyc;
  int obs_pol[$], obs_code[$], obs_len[$];
  bit seg_on, seg_bad;
  int seg_pol, seg_code, seg_len;
  logic prev_en, prev_pol;

  // Reference model output
  int exp_pol[$], exp_amp[$];

  memx_write_verify_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_tol    (req_tol),
    .abort      (abort),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_code   (rsp_code),
    .rsp_pulses (rsp_pulses),
    .drv_en     (drv_en),
    .drv_pol    (drv_pol),
    .drv_code   (drv_code),
    .adc_start  (adc_start),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cell/ADC responder and driver monitor, all on the falling edge.
  always @(negedge clk) begin
    if (adc_valid) adc_valid = 1'b0;
    if (pending) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        pending   = 1'b0;
        adc_valid = 1'b1;
        adc_data  = DATA_W'(g);
      end
    end
    if (adc_start === 1'b1) begin
      start_cyc = cyc;
      if (adc_mode != 1) begin
        pending = 1'b1;
        lat_cnt = (adc_mode == 2) ? adc_fixed_lat : int'($urandom_range(1, 12));
      end
    end
    if (drv_en === 1'b1) begin
      if (!seg_on) begin
        seg_on = 1'b1; seg_pol = int'(drv_pol); seg_code = int'(drv_code);
        seg_len = 0; seg_bad = 1'b0;
      end
      seg_len++;
      if (int'(drv_pol) != seg_pol || int'(drv_code) != seg_code) seg_bad = 1'b1;
      if (prev_en === 1'b1) check("drv_pol_stable", drv_pol, prev_pol);
    end else begin
      check("drv_code_idle", drv_code, 0);
      if (seg_on) begin
        seg_on = 1'b0;
        if (seg_code != int'(V_READ)) begin
          obs_pol.push_back(seg_pol);
          obs_code.push_back(seg_code);
          obs_len.push_back(seg_bad ? -1 : seg_len);
          if (seg_pol == 1) g = (g + set_gain > 255) ? 255 : g + set_gain;
          else              g = (g - rst_gain < 0) ? 0 : g - rst_gain;
        end
      end
    end
    prev_en  = drv_en;
    prev_pol = drv_pol;
  end

  // Request-level prediction straight from the write-verify rules.
  task automatic model(input int g0, input int t, input int tol, input int sg, input int rg,
                       output int st, output int code, output int np);
    int gg, amp, prev, pol, d;
    gg = g0; np = 0; amp = 24; prev = 1; st = -1;
    exp_pol.delete(); exp_amp.delete();
    for (int k = 0; k <= 33 && st < 0; k++) begin
      d = (gg > t) ? gg - t : t - gg;
      if (d <= tol) st = 0;
      else if (np == 32) st = 1;
      else begin
        pol = (gg < t) ? 1 : 0;
        if (np == 0 || pol != prev) amp = 24;
        else amp = (amp + 2 > 63) ? 63 : amp + 2;
        exp_pol.push_back(pol);
        exp_amp.push_back(amp);
        prev = pol;
        np++;
        gg = pol ? ((gg + sg > 255) ? 255 : gg + sg) : ((gg - rg < 0) ? 0 : gg - rg);
      end
    end
    code = gg;
  endtask

  task automatic wait_rsp(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    if (!got) check("rsp_valid_wait", rsp_valid, 1);
  endtask

  task automatic issue(input int t, input int tol);
    @(negedge clk);
    req_target = DATA_W'(t);
    req_tol    = TOL_W'(tol);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, rsp_valid, 0);
    check({name, "_req_ready"}, req_ready, 1);
  endtask

  task automatic run_req(input string name, input int g0, input int t, input int tol,
                         input int sg, input int rg);
    int st, code, np, n;
    bit got;
    model(g0, t, tol, sg, rg, st, code, np);
    g = g0; set_gain = sg; rst_gain = rg;
    obs_pol.delete(); obs_code.delete(); obs_len.delete();
    issue(t, tol);
    wait_rsp(4000, got);
    if (got) begin
      check({name, "_status"}, rsp_status, st);
      check({name, "_code"}, rsp_code, code);
      check({name, "_pulses"}, rsp_pulses, np);
      check({name, "_drv_en"}, drv_en, 0);
      check({name, "_npulses_seen"}, obs_pol.size(), np);
      n = (obs_pol.size() < exp_pol.size()) ? obs_pol.size() : exp_pol.size();
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_p%0d_pol", name, i), obs_pol[i], exp_pol[i]);
        check($sformatf("%s_p%0d_amp", name, i), obs_code[i], exp_amp[i]);
        check($sformatf("%s_p%0d_len", name, i), obs_len[i], PULSE_CYC);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check({name, "_hold"}, rsp_code, code);
      end
      handshake(name);
    end
  endtask

  initial begin
    bit got;
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_target = '0; req_tol = '0; abort = 1'b0;
    rsp_ready = 1'b0; adc_valid = 1'b0; adc_data = '0;
    adc_mode = 0; adc_fixed_lat = 1; pending = 1'b0; g = 0; set_gain = 0; rst_gain = 0;
    seg_on = 1'b0; prev_en = 1'b0; prev_pol = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_drv_en", drv_en, 0);
    check("rst_drv_code", drv_code, 0);
    check("rst_adc_start", adc_start, 0);
    rst = 1'b0;
    @(negedge clk);

    run_req("in_tol", 100, 100, 2, 5, 5);
    run_req("set4", 80, 100, 1, 5, 5);
    run_req("overshoot", 90, 100, 0, 20, 5);
    run_req("budget", 50, 200, 0, 0, 0);

    // ADC never answers: timeout 255 cycles after the start strobe.
    adc_mode = 1; g = 77;
    issue(77, 0);
    wait_rsp(400, got);
    if (got) begin
      check("tmo_status", rsp_status, 2);
      check("tmo_code", rsp_code, 0);
      check("tmo_pulses", rsp_pulses, 0);
      check("tmo_drv_en", drv_en, 0);
      check("tmo_latency", cyc - start_cyc, 256);
      handshake("tmo");
    end

    // Result arriving on the expiry cycle is accepted.
    adc_mode = 2; adc_fixed_lat = 255; g = 77;
    issue(77, 0);
    wait_rsp(400, got);
    if (got) begin
      check("expiry_status", rsp_status, 0);
      check("expiry_code", rsp_code, 77);
      check("expiry_latency", cyc - start_cyc, 257);
      handshake("expiry");
    end
    adc_mode = 0;

    // Abort in the 7th cycle of the first pulse.
    g = 80; set_gain = 5; rst_gain = 5;
    issue(100, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (drv_en === 1'b1 && drv_code !== V_READ) seen = 1'b1;
    end
    check("abort_pulse_seen", seen, 1);
    repeat (6) @(negedge clk);
    check("abort_pulse_active", drv_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_drv_en", drv_en, 0);
    check("abort_rsp_valid", rsp_valid, 1);
    check("abort_status", rsp_status, 3);
    check("abort_code", rsp_code, 80);
    check("abort_pulses", rsp_pulses, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold%0d_valid", i), rsp_valid, 1);
      check($sformatf("abort_hold%0d_status", i), rsp_status, 3);
      check($sformatf("abort_hold%0d_code", i), rsp_code, 80);
    end
    handshake("abort");

    // Async reset mid-pulse clears outputs without a clock edge.
    g = 20; set_gain = 5;
    issue(120, 0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (drv_en === 1'b1 && drv_code !== V_READ) seen = 1'b1;
    end
    check("arst_pulse_seen", seen, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_drv_en", drv_en, 0);
    check("arst_drv_code", drv_code, 0);
    check("arst_drv_pol", drv_pol, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_adc_start", adc_start, 0);
    @(negedge clk);
    rst = 1'b0;
    pending = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      int g0, t, tol, sg, rg;
      g0  = int'($urandom_range(0, 255));
      t   = int'($urandom_range(0, 255));
      tol = int'($urandom_range(0, 15));
      sg  = int'($urandom_range(1, 20));
      rg  = int'($urandom_range(1, 20));
      run_req($sformatf("rnd%0d", i), g0, t, tol, sg, rg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
